// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared types and constants for the four-requester arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, GRANT, GAP)
//   - ARB_N       : number of requesters
//   - ARB_IDX_W   : width of an encoded requester index
//   - idx_to_onehot() : encoded index -> one-hot requester vector
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_N     = 4;
    localparam int ARB_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
        logic [ARB_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// ---------------------------------------------------------------------------
// prio_enc4
//   Combinational 4:2 priority encoder; the highest set index wins.
//   Ports:
//     req_i [3:0] : request vector
//     idx_o [1:0] : index of the highest set bit (0 when none set)
//     vld_o       : at least one bit of req_i is set
// ---------------------------------------------------------------------------
module prio_enc4
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req_i,
    output logic [ARB_IDX_W-1:0] idx_o,
    output logic                 vld_o
);

    // Ascending scan: the last hit, i.e. the highest index, is what remains.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < ARB_N; i++) begin
            if (req_i[i]) begin
                idx_o = ARB_IDX_W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter4.sv
// ---------------------------------------------------------------------------
// req_arbiter4
//   Four-requester arbiter for one shared resource. Picks an owner in IDLE,
//   holds the grant until done / withdrawal / hold timeout, then spends one
//   GAP cycle with all grants low before arbitrating again. All outputs are
//   registered.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : rotating priority starting after the last granted index
//     undefined : fixed priority 3>2>1>0 with a one-round preemption mask
//
//   Parameters:
//     MAX_HOLD : max grant cycles while another requester waits (0 = none)
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     req [3:0] : request lines (bit 3 highest fixed priority)
//     done      : owner finished, releases the grant (ignored when idle)
//     gnt [3:0] : one-hot grant, zero when no grant is active
//     gnt_idx   : encoded index of the granted requester
//     gnt_vld   : a grant is active
//     preempt   : one-cycle pulse in the GAP that follows a timeout release
//     dbg_state : current FSM state (arb_state_t encoding), for observation
//
//   Handshake: a requester holds req high until it is granted and keeps it
//   high for the whole ownership; done (or dropping req) ends the ownership
//   at the next rising edge. Non-owner req changes during GRANT are only
//   seen at the next IDLE.
// ---------------------------------------------------------------------------
module req_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic [ARB_N-1:0]     gnt,
    output logic [ARB_IDX_W-1:0] gnt_idx,
    output logic                 gnt_vld,
    output logic                 preempt,
    output logic [1:0]           dbg_state
);

    // A zero-width counter is illegal, so MAX_HOLD=0 keeps a 1-bit stub.
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t           state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [ARB_N-1:0]     gnt_q, gnt_d;
    logic [ARB_IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic                 preempt_q, preempt_d;

    logic [ARB_IDX_W-1:0] sel_idx;
    logic                 sel_vld;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ARB_IDX_W-1:0] last_idx_q, last_idx_d;
    logic [ARB_IDX_W-1:0] start_idx;
    logic [ARB_IDX_W-1:0] src_idx;
    logic [ARB_N-1:0]     rot_req;
    logic [ARB_IDX_W-1:0] enc_idx;

    // Candidate k (k=0 first) is req[start+k]; it is placed at encoder bit
    // 3-k so that the highest-index-wins encoder picks the earliest one.
    always_comb begin
        start_idx = last_idx_q + 1'b1;
        src_idx   = '0;
        rot_req   = '0;
        for (int k = 0; k < ARB_N; k++) begin
            src_idx              = start_idx + ARB_IDX_W'(k);
            rot_req[ARB_N-1-k]   = req[src_idx];
        end
    end

    prio_enc4 u_enc (
        .req_i (rot_req),
        .idx_o (enc_idx),
        .vld_o (sel_vld)
    );

    assign sel_idx = start_idx + (ARB_IDX_W'(ARB_N - 1) - enc_idx);
`else
    logic [ARB_N-1:0] mask_q, mask_d;
    logic [ARB_N-1:0] masked_req;
    logic [ARB_N-1:0] cand_req;

    // A just-preempted requester sits out one round unless nobody else asks.
    assign masked_req = req & ~mask_q;
    assign cand_req   = (masked_req != '0) ? masked_req : req;

    prio_enc4 u_enc (
        .req_i (cand_req),
        .idx_o (sel_idx),
        .vld_o (sel_vld)
    );
`endif

    // Release qualification while in GRANT.
    logic owner_req;
    logic others_wait;
    logic timeout;
    logic release_now;
    logic timeout_only;

    assign owner_req    = req[gnt_idx_q];
    assign others_wait  = (req & ~gnt_q) != '0;
    assign timeout      = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_wait;
    assign release_now  = done || !owner_req || timeout;
    assign timeout_only = timeout && !done && owner_req;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            preempt_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_idx_q <= ARB_IDX_W'(ARB_N - 1);
`else
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            preempt_q  <= preempt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_idx_q <= last_idx_d;
`else
            mask_q     <= mask_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_idx_d = last_idx_q;
`else
        mask_d     = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d    = GRANT;
                    hold_d     = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_idx_d = sel_idx;
`else
                    mask_d     = '0;
`endif
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = GAP;
`ifndef ARB_ROUND_ROBIN_EN
                    if (timeout_only) begin
                        mask_d = idx_to_onehot(gnt_idx_q);
                    end
`endif
                end else if (hold_q != HOLD_LAST) begin
                    // Stops at HOLD_LAST; with a waiter present that is a timeout.
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        gnt_vld_d = (state_d == GRANT);
        gnt_idx_d = ((state_q == IDLE) && sel_vld) ? sel_idx : gnt_idx_q;
        gnt_d     = gnt_vld_d ? idx_to_onehot(gnt_idx_d) : '0;
        preempt_d = (state_q == GRANT) && release_now && timeout_only;
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_vld   = gnt_vld_q;
    assign preempt   = preempt_q;
    assign dbg_state = state_q;

endmodule

// File: doc/req_arbiter4.md
# req_arbiter4

Four-requester arbiter that shares a single downstream resource, such as a bus or datapath port, among requesters `req[3:0]`. It selects one requester with a 4:2 priority encode, holds the grant until the owner signals completion, and force-releases an owner that exceeds a configurable hold limit. All outputs are registered; the block sits between the requester bank and the shared resource's select mux.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held while another requester waits. 0 = no limit.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: request lines. Bit 3 has highest fixed priority.
- `done` input 1: owner finished; releases the grant. Ignored when `gnt_vld`=0.
- `gnt` output 4: one-hot grant, all zero when idle.
- `gnt_idx` output 2: encoded index of the granted requester.
- `gnt_vld` output 1: a grant is active.
- `preempt` output 1: one-cycle pulse when a grant is force-released by timeout.

## Operation
- State machine:
  - IDLE → GRANT when any `req` bit is set.
  - GRANT → GAP on release.
  - GAP → IDLE unconditionally.
- GAP is a mandatory one-cycle guard with all grants low.
- Selection in IDLE:
  - Without round-robin: highest set bit of `req & ~mask`.
  - If the masked vector is zero, unmasked `req` is used.
- `mask` is one-hot on the last preempted index and cleared at the next grant. A preempted requester loses exactly one arbitration round.
- Release conditions in GRANT, any one is sufficient:
  - `done`=1.
  - `req[gnt_idx]`=0, i.e. the requester withdrew.
  - Timeout: `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD`-1 and `req & ~gnt`≠0.
- Simultaneous release causes give a single release. `preempt` pulses only when timeout is the sole cause.
- Hold counter:
  - `hold_cnt` width is $clog2(MAX_HOLD+1).
  - It clears on entry to GRANT and increments each GRANT cycle.
  - It saturates at `MAX_HOLD`-1 while no other requester is waiting.
- `gnt` is always equal to `1<<gnt_idx` when `gnt_vld`=1, and 0 otherwise.
- A `req` change during GRANT on a non-owner index has no effect until the next IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `preempt`=0.
  - `hold_cnt`=0, `mask`=0, `last_idx`=3.
- Reset is asynchronous and takes effect mid-grant immediately. The first grant after `rst_n` deasserts takes at least one clock.
- Latency: `req` sampled high in IDLE at edge N gives `gnt_vld`=1 after edge N (visible in cycle N+1).
- Release: condition true at edge M gives `gnt_vld`=0 in cycle M+1 (GAP) and IDLE in M+2. The earliest new grant is visible in cycle M+3.
- `preempt` is high for exactly the GAP cycle following a timeout.
- Minimum grant length is 1 cycle. The owner's `done` is sampled only while `gnt_vld`=1.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- Defined:
  - Selection searches from `last_idx`+1 upward with wrap-around (3→0).
  - `last_idx` updates to the granted index at each grant.
  - The preemption mask is unused, since rotation already guarantees fairness.
- Undefined:
  - Fixed priority 3>2>1>0 with the one-round preemption mask.
  - `last_idx` is held at its reset value.

## Structure
- Package `arb_pkg` contains:
  - State enum `arb_state_t` {IDLE, GRANT, GAP}.
  - Constants `ARB_N`=4 and `ARB_IDX_W`=2.
- Sub-module `prio_enc4`: combinational 4:2 priority encoder with valid (highest index wins).
  - Fixed priority uses one instance.
  - Round-robin uses it on the rotated request vector, with the index rotated back.

## Test plan
- Reset with `req`=4'b1111: after release of `rst_n`, `gnt`=4'b1000, `gnt_idx`=3 one cycle later. In round-robin mode `gnt_idx`=0.
- `req`=4'b0110 with `done` pulsed after 3 cycles of grant: first `gnt_idx`=2, then the GAP cycle with `gnt_vld`=0, then `gnt_idx`=1 (fixed priority re-grants 2 if it is still requesting).
- `MAX_HOLD`=4, `req`=4'b1001 held constant with no `done`: `gnt_idx`=3 for 4 cycles, `preempt` pulses for 1 cycle, next `gnt_idx`=0.
- Owner drops `req[gnt_idx]` in the same cycle as `done`=1: single release, `preempt`=0, no double GAP.
- `rst_n` asserted mid-grant: `gnt`, `gnt_vld` and `preempt` go to 0 without a clock. Round-robin `last_idx` returns to 3.
- Round-robin, all requesters held with `done` every grant: grant order 0,1,2,3,0 with one GAP cycle between each.
